// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline registers.
// Resolves memwait > mul/div > branch > load-use and counts cycles with pc_en=0.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_dest,
    input  logic              ex_muldiv,
    input  logic              ex_is_div,
    input  logic              ex_branch_taken,
    input  logic              mem_access,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              muldiv_busy,
    output logic              muldiv_done,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] lat;
    logic             memwait;
    logic             md_start;
    logic             md_stall;
    logic             md_fin;
    logic             load_use;

    assign memwait  = mem_access & ~mem_ready;
    assign lat      = ex_is_div ? DIV_L : MUL_L;
    assign md_start = (state == IDLE) & ex_muldiv & ~memwait;
    // The countdown starts at L-2 so the op holds EX for exactly L non-waiting cycles.
    assign md_stall = (md_start & (lat != ONE)) |
                      ((state == BUSY) & ~memwait & (cnt != '0));
    assign md_fin   = (md_start & (lat == ONE)) |
                      ((state == BUSY) & ~memwait & (cnt == '0));
    assign load_use = ex_mem_read & (ex_dest != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_dest)) |
                       (id_uses_rt & (id_rt == ex_dest)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (md_start && (lat != ONE)) begin
            state_nxt = BUSY;
            cnt_nxt   = lat - TWO;
        end else if ((state == BUSY) && !memwait) begin
            if (cnt != '0)
                cnt_nxt = cnt - ONE;
            else
                state_nxt = IDLE;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        muldiv_busy  = (state == BUSY);
        muldiv_done  = 1'b0;
        if (!rst_n) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            muldiv_busy  = 1'b0;
        end else if (memwait) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else begin
            muldiv_done = md_fin;
            if (md_stall) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
            end else if (ex_branch_taken) begin
                // The ID instruction is squashed, so any load-use on it is moot.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, mul/div sequencing, memwait,
// branch priority, reset abort and stall counter saturation.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_dest;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_muldiv, ex_is_div;
    logic        ex_branch_taken, mem_access, mem_ready;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        muldiv_busy, muldiv_done;
    logic [31:0] stall_cycles;

    logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush;
    logic        s_muldiv_busy, s_muldiv_done;
    logic [3:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;

    logic [4:0] en_v, fl_v;
    assign en_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl_v = {1'b0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .ex_muldiv(ex_muldiv),
        .ex_is_div(ex_is_div), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
        .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6), .PERF_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .ex_muldiv(ex_muldiv),
        .ex_is_div(ex_is_div), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
        .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush),
        .muldiv_busy(s_muldiv_busy), .muldiv_done(s_muldiv_done),
        .stall_cycles(s_stall_cycles)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_dest = 5'd0; ex_muldiv = 1'b0; ex_is_div = 1'b0;
        ex_branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        ex_muldiv = 1'b1;
        ex_mem_read = 1'b1; ex_dest = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
        cyc();
        #2;
        checks++;
        if (en_v !== 5'b11111) begin
            errors++; $display("FAIL reset_en: got %b expected 11111", en_v);
        end
        checks++;
        if (fl_v !== 5'b01111) begin
            errors++; $display("FAIL reset_flush: got %b expected 01111", fl_v);
        end
        checks++;
        if ({muldiv_busy, muldiv_done} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_done: got %b expected 00", {muldiv_busy, muldiv_done});
        end
        cyc();
        idle_inputs();
        rst_n = 1'b1;
        #2;
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
        end
        checks++;
        if ({en_v, fl_v, muldiv_busy} !== {5'b11111, 5'b00000, 1'b0}) begin
            errors++; $display("FAIL reset_release_default: got %b expected 11111000000", {en_v, fl_v, muldiv_busy});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        cyc();
        ex_mem_read = 1'b1; ex_dest = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        #2;
        checks++;
        if ({pc_en, if_id_en, id_ex_en, id_ex_flush} !== 4'b0011) begin
            errors++; $display("FAIL load_use_rs: got %b expected 0011", {pc_en, if_id_en, id_ex_en, id_ex_flush});
        end
        cyc();
        idle_inputs();
        #2;
        checks++;
        if ({pc_en, id_ex_flush} !== 2'b10) begin
            errors++; $display("FAIL load_use_after: got %b expected 10", {pc_en, id_ex_flush});
        end
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++; $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
        end
        ex_mem_read = 1'b1; ex_dest = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        checks++;
        if ({pc_en, if_id_en, id_ex_flush} !== 3'b110) begin
            errors++; $display("FAIL load_use_r0: got %b expected 110", {pc_en, if_id_en, id_ex_flush});
        end
        ex_dest = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd1;
        #1;
        checks++;
        if ({pc_en, if_id_en, id_ex_flush} !== 3'b001) begin
            errors++; $display("FAIL load_use_rt: got %b expected 001", {pc_en, if_id_en, id_ex_flush});
        end
        id_uses_rt = 1'b0; id_rs = 5'd7; id_uses_rs = 1'b0;
        #1;
        checks++;
        if ({pc_en, if_id_en, id_ex_flush} !== 3'b110) begin
            errors++; $display("FAIL load_use_unused_src: got %b expected 110", {pc_en, if_id_en, id_ex_flush});
        end
        idle_inputs();
    endtask

    task automatic test_mul();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            idle_inputs();
            ex_muldiv = 1'b1;
            #2;
            checks++;
            if ({pc_en, if_id_en, id_ex_en, ex_mem_en, ex_mem_flush} !==
                {k == 4, k == 4, k == 4, 1'b1, k != 4}) begin
                errors++; $display("FAIL mul_stall c%0d: got %b expected %b", k,
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, ex_mem_flush},
                    {k == 4, k == 4, k == 4, 1'b1, k != 4});
            end
            checks++;
            if ({muldiv_busy, muldiv_done} !== {k > 1, k == 4}) begin
                errors++; $display("FAIL mul_busy_done c%0d: got %b expected %b", k,
                    {muldiv_busy, muldiv_done}, {k > 1, k == 4});
            end
        end
        cyc();
        idle_inputs();
        #2;
        checks++;
        if ({muldiv_busy, muldiv_done, pc_en} !== 3'b001) begin
            errors++; $display("FAIL mul_idle_after: got %b expected 001", {muldiv_busy, muldiv_done, pc_en});
        end
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++; $display("FAIL mul_count: got %0d expected 3", stall_cycles);
        end
    endtask

    task automatic test_div_memwait();
        logic mw;
        do_reset();
        for (int k = 1; k <= 37; k++) begin
            cyc();
            idle_inputs();
            ex_muldiv = 1'b1; ex_is_div = 1'b1;
            mw = (k >= 11) && (k <= 15);
            mem_access = mw; mem_ready = !mw;
            #2;
            checks++;
            if (mw) begin
                if ({pc_en, ex_mem_en, mem_wb_en, mem_wb_flush, muldiv_done, muldiv_busy} !== 6'b001101) begin
                    errors++; $display("FAIL div_memwait c%0d: got %b expected 001101", k,
                        {pc_en, ex_mem_en, mem_wb_en, mem_wb_flush, muldiv_done, muldiv_busy});
                end
            end else begin
                if ({pc_en, ex_mem_flush, mem_wb_flush, muldiv_done, muldiv_busy} !==
                    {k == 37, k != 37, 1'b0, k == 37, k > 1}) begin
                    errors++; $display("FAIL div_run c%0d: got %b expected %b", k,
                        {pc_en, ex_mem_flush, mem_wb_flush, muldiv_done, muldiv_busy},
                        {k == 37, k != 37, 1'b0, k == 37, k > 1});
                end
            end
        end
        cyc();
        idle_inputs();
        #2;
        checks++;
        if (stall_cycles !== 32'd36) begin
            errors++; $display("FAIL div_count: got %0d expected 36", stall_cycles);
        end
        checks++;
        if (muldiv_busy !== 1'b0) begin
            errors++; $display("FAIL div_idle_after: got %b expected 0", muldiv_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done, exp_busy;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            cyc();
            idle_inputs();
            ex_muldiv = 1'b1;
            mem_access = (k == 4); mem_ready = (k != 4);
            #2;
            exp_done = (k == 5) || (k == 9);
            exp_busy = (k >= 2 && k <= 5) || (k >= 7);
            checks++;
            if ({pc_en, muldiv_done, muldiv_busy} !== {exp_done, exp_done, exp_busy}) begin
                errors++; $display("FAIL b2b c%0d: got %b expected %b", k,
                    {pc_en, muldiv_done, muldiv_busy}, {exp_done, exp_done, exp_busy});
            end
        end
        cyc();
        idle_inputs();
        #2;
        checks++;
        if (stall_cycles !== 32'd7) begin
            errors++; $display("FAIL b2b_count: got %0d expected 7", stall_cycles);
        end
    endtask

    task automatic test_branch_load_use();
        do_reset();
        cyc();
        ex_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_dest = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
        #2;
        checks++;
        if ({pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush} !== 6'b111110) begin
            errors++; $display("FAIL branch_over_load_use: got %b expected 111110",
                {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush});
        end
        cyc();
        idle_inputs();
        #2;
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL branch_count: got %0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cyc();
            idle_inputs();
            ex_muldiv = 1'b1; ex_is_div = 1'b1;
            if (k == 10) rst_n = 1'b0;
            #2;
        end
        checks++;
        if ({en_v, fl_v, muldiv_busy, muldiv_done} !== {5'b11111, 5'b01111, 2'b00}) begin
            errors++; $display("FAIL reset_busy_outputs: got %b expected 11111011110",
                {en_v, fl_v, muldiv_busy, muldiv_done});
        end
        cyc();
        rst_n = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if ({muldiv_busy, muldiv_done, pc_en} !== 3'b001) begin
            errors++; $display("FAIL reset_busy_idle: got %b expected 001", {muldiv_busy, muldiv_done, pc_en});
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_busy_count: got %0d expected 0", stall_cycles);
        end
        cyc();
        #2;
        checks++;
        if ({muldiv_busy, muldiv_done} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_no_done: got %b expected 00", {muldiv_busy, muldiv_done});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            cyc();
            idle_inputs();
            mem_access = 1'b1; mem_ready = 1'b0;
            #2;
            if (k == 15) begin
                checks++;
                if (s_stall_cycles !== 4'd14) begin
                    errors++; $display("FAIL sat_before: got %0d expected 14", s_stall_cycles);
                end
            end
        end
        cyc();
        idle_inputs();
        #2;
        checks++;
        if (s_stall_cycles !== 4'd15) begin
            errors++; $display("FAIL sat_hold: got %0d expected 15", s_stall_cycles);
        end
        checks++;
        if (stall_cycles !== 32'd20) begin
            errors++; $display("FAIL sat_wide_count: got %0d expected 20", stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_div_memwait();
        test_back_to_back();
        test_branch_load_use();
        test_reset_busy();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
